// File: rtl/cic_pkg.sv
// Shared types for the CIC interpolator/decimator control blocks.
// Stats widths are only used when CIC_INTERP_CTRL_STATS_EN is defined.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } cic_ctrl_state_t;

  localparam int STATS_UNDERFLOW_WIDTH = 16;
  localparam int STATS_SAMPLE_WIDTH    = 32;

endpackage

// File: rtl/cic_interp_ctrl_if.sv
// Handshake/strobe bundle for cic_interp_ctrl; the slave modport is the controller side.
// Stats signals exist only when CIC_INTERP_CTRL_STATS_EN is defined.
interface cic_interp_ctrl_if #(
  parameter int RATE_WIDTH = 8
);
  import cic_pkg::*;

  logic                  i_enable;
  logic [RATE_WIDTH-1:0] i_rate;
  logic                  i_valid;
  logic                  o_ready;
  logic                  o_comb_ready;
  logic                  o_stuff_sel;
  logic                  o_integ_ready;
  logic                  i_out_ready;
  logic                  o_out_valid;
  logic                  o_underflow;
  logic                  o_busy;
`ifdef CIC_INTERP_CTRL_STATS_EN
  logic [STATS_UNDERFLOW_WIDTH-1:0] o_underflow_count;
  logic [STATS_SAMPLE_WIDTH-1:0]    o_sample_count;
`endif

  modport slave (
    input  i_enable, i_rate, i_valid, i_out_ready,
    output o_ready, o_comb_ready, o_stuff_sel, o_integ_ready,
    output o_out_valid, o_underflow, o_busy
`ifdef CIC_INTERP_CTRL_STATS_EN
    , output o_underflow_count, o_sample_count
`endif
  );

  modport master (
    output i_enable, i_rate, i_valid, i_out_ready,
    input  o_ready, o_comb_ready, o_stuff_sel, o_integ_ready,
    input  o_out_valid, o_underflow, o_busy
`ifdef CIC_INTERP_CTRL_STATS_EN
    , input o_underflow_count, o_sample_count
`endif
  );

endinterface

// File: rtl/cic_phase_counter.sv
// Modulo-N counter with enable and a combinational wrap flag; modulus must be >= 1.
module cic_phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign wrap = enable & (count == (modulus - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/cic_interp_ctrl.sv
// Rate sequencer for the I/Q CIC interpolator: primes the combs, then paces integrator ticks.
// Optional accept/underflow statistics are built when CIC_INTERP_CTRL_STATS_EN is defined.
module cic_interp_ctrl
  import cic_pkg::*;
#(
  parameter int RATE_WIDTH   = 8,
  parameter int COMB_STAGES  = 3,
  parameter int INTEG_STAGES = 3
) (
  input logic          i_clock,
  input logic          i_reset,
  cic_interp_ctrl_if.slave bus
);

  localparam int PW = (COMB_STAGES > 1) ? $clog2(COMB_STAGES) : 1;
  localparam int FW = $clog2(INTEG_STAGES + 1);
  localparam logic [PW-1:0]         PRIME_LAST = PW'(COMB_STAGES - 1);
  localparam logic [FW-1:0]         FILL_FULL  = FW'(INTEG_STAGES);
  localparam logic [RATE_WIDTH-1:0] RATE_ONE   = RATE_WIDTH'(1);

  cic_ctrl_state_t       state;
  logic [RATE_WIDTH-1:0] rate_q;
  logic [RATE_WIDTH-1:0] phase;
  logic [PW-1:0]         prime_cnt;
  logic [FW-1:0]         fill_cnt;

  logic start, in_symbol, at_boundary, ready, accept, tick, underflow, wrap, next_boundary;

  always_comb begin
    start       = (state == IDLE) & bus.i_enable;
    in_symbol   = (state == RUN) | (state == DRAIN);
    at_boundary = (phase == '0);
    ready       = 1'b0;
    case (state)
      PRIME:   ready = 1'b1;
      RUN:     ready = bus.i_out_ready & at_boundary;
      default: ready = 1'b0;
    endcase
    accept    = ready & bus.i_valid;
    // A boundary tick needs a fresh sample; DRAIN never accepts, so it only ticks mid-symbol.
    tick      = in_symbol & bus.i_out_ready &
                (~at_boundary | ((state == RUN) & bus.i_valid));
    underflow = (state == RUN) & at_boundary & bus.i_out_ready & ~bus.i_valid;
    next_boundary = tick ? wrap : at_boundary;
  end

  assign bus.o_ready       = ready;
  assign bus.o_comb_ready  = accept;
  assign bus.o_stuff_sel   = in_symbol & at_boundary;
  assign bus.o_integ_ready = tick;
  assign bus.o_out_valid   = tick & (fill_cnt == FILL_FULL);
  assign bus.o_underflow   = underflow;
  assign bus.o_busy        = (state != IDLE);

  cic_phase_counter #(.WIDTH(RATE_WIDTH)) u_phase (
    .clk     (i_clock),
    .rst     (i_reset),
    .clear   (start),
    .enable  (tick),
    .modulus (rate_q),
    .count   (phase),
    .wrap    (wrap)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      rate_q    <= RATE_ONE;
      prime_cnt <= '0;
      fill_cnt  <= '0;
    end else begin
      if (tick && fill_cnt != FILL_FULL) begin
        fill_cnt <= fill_cnt + FW'(1);
      end
      case (state)
        IDLE: begin
          if (bus.i_enable) begin
            rate_q    <= (bus.i_rate == '0) ? RATE_ONE : bus.i_rate;
            prime_cnt <= '0;
            fill_cnt  <= '0;
            state     <= PRIME;
          end
        end
        PRIME: begin
          if (accept) begin
            prime_cnt <= prime_cnt + PW'(1);
          end
          if (!bus.i_enable) begin
            state <= IDLE;
          end else if (accept && prime_cnt == PRIME_LAST) begin
            state <= RUN;
          end
        end
        RUN: begin
          // The symbol in flight always completes before going idle.
          if (!bus.i_enable) begin
            state <= next_boundary ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (wrap) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CIC_INTERP_CTRL_STATS_EN
  logic [STATS_UNDERFLOW_WIDTH-1:0] underflow_count;
  logic [STATS_SAMPLE_WIDTH-1:0]    sample_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      underflow_count <= '0;
      sample_count    <= '0;
    end else begin
      if (start) begin
        underflow_count <= '0;
      end else if (underflow && underflow_count != '1) begin
        underflow_count <= underflow_count + STATS_UNDERFLOW_WIDTH'(1);
      end
      if (accept) begin
        sample_count <= sample_count + STATS_SAMPLE_WIDTH'(1);
      end
    end
  end

  assign bus.o_underflow_count = underflow_count;
  assign bus.o_sample_count    = sample_count;
`endif

endmodule
